// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: two-requester queued, round-robin arbiter for one register file write port,
// with a pending-write bitmap and a sticky cross-requester ordering hazard flag.
module regfile_wr_arbiter #(
  parameter int BITWIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_sel,
  input  logic [BITWIDTH-1:0] a_data,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [2:0]          b_sel,
  input  logic [BITWIDTH-1:0] b_data,
  output logic                wr_en,
  output logic [2:0]          wr_sel,
  output logic [BITWIDTH-1:0] wr_data,
  output logic [7:0]          pend,
  output logic                err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [DEPTH-1:0]    r_a_v, r_b_v;
  logic [2:0]          r_a_sel [DEPTH];
  logic [2:0]          r_b_sel [DEPTH];
  logic [BITWIDTH-1:0] r_a_data [DEPTH];
  logic [BITWIDTH-1:0] r_b_data [DEPTH];
  logic [AW-1:0]       r_a_wp, r_a_rp, r_b_wp, r_b_rp;
  logic                r_prio_b, r_err;
  logic                w_a_ne, w_b_ne, w_a_acc, w_b_acc, w_gnt_a, w_gnt_b, w_a_hit, w_b_hit;
  assign w_a_ne  = |r_a_v;
  assign w_b_ne  = |r_b_v;
  assign a_ready = rst & ~(&r_a_v);
  assign b_ready = rst & ~(&r_b_v);
  assign w_a_acc = a_valid & a_ready;
  assign w_b_acc = b_valid & b_ready;
  assign w_gnt_b = w_b_ne & (~w_a_ne | r_prio_b);
  assign w_gnt_a = w_a_ne & ~w_gnt_b;
  assign wr_en   = w_a_ne | w_b_ne;
  assign wr_sel  = w_gnt_a ? r_a_sel[r_a_rp] : w_gnt_b ? r_b_sel[r_b_rp] : 3'd0;
  assign wr_data = w_gnt_a ? r_a_data[r_a_rp] : w_gnt_b ? r_b_data[r_b_rp] : '0;
  assign err     = r_err;
  // w_a_hit: incoming A collides with a queued B entry; w_b_hit the reverse
  always_comb begin
    pend = 8'd0;
    w_a_hit = 1'b0;
    w_b_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_a_v[i]) begin
        pend[r_a_sel[i]] = 1'b1;
        w_b_hit = w_b_hit | (r_a_sel[i] == b_sel);
      end
      if (r_b_v[i]) begin
        pend[r_b_sel[i]] = 1'b1;
        w_a_hit = w_a_hit | (r_b_sel[i] == a_sel);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_a_acc) begin
      r_a_sel[r_a_wp]  <= a_sel;
      r_a_data[r_a_wp] <= a_data;
    end
    if (w_b_acc) begin
      r_b_sel[r_b_wp]  <= b_sel;
      r_b_data[r_b_wp] <= b_data;
    end
  end
  // enqueue slot is always empty and dequeue slot always full, so they never coincide
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_v    <= '0;
      r_b_v    <= '0;
      r_a_wp   <= '0;
      r_a_rp   <= '0;
      r_b_wp   <= '0;
      r_b_rp   <= '0;
      r_prio_b <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      if (w_a_acc) begin
        r_a_v[r_a_wp] <= 1'b1;
        r_a_wp        <= r_a_wp + 1'b1;
      end
      if (w_gnt_a) begin
        r_a_v[r_a_rp] <= 1'b0;
        r_a_rp        <= r_a_rp + 1'b1;
      end
      if (w_b_acc) begin
        r_b_v[r_b_wp] <= 1'b1;
        r_b_wp        <= r_b_wp + 1'b1;
      end
      if (w_gnt_b) begin
        r_b_v[r_b_rp] <= 1'b0;
        r_b_rp        <= r_b_rp + 1'b1;
      end
      if (w_gnt_a | w_gnt_b)
        r_prio_b <= w_gnt_a;
      if ((w_a_acc & w_a_hit) | (w_b_acc & w_b_hit) | (w_a_acc & w_b_acc & (a_sel == b_sel)))
        r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed plus random stimulus checked against a queue-based reference model.
module tb_regfile_wr_arbiter;
  localparam int BW = 16;
  localparam int D = 2;
  logic clk = 0;
  logic rst = 0;
  logic a_valid = 0, b_valid = 0;
  logic [2:0] a_sel = 0, b_sel = 0;
  logic [BW-1:0] a_data = 0, b_data = 0;
  logic a_ready, b_ready, wr_en, err;
  logic [2:0] wr_sel;
  logic [BW-1:0] wr_data;
  logic [7:0] pend;
  int checks = 0, errors = 0;
  logic [2:0] qa_s[$], qb_s[$];
  logic [BW-1:0] qa_d[$], qb_d[$];
  bit last_b = 1, m_err = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.BITWIDTH(BW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_sel(a_sel), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_sel(b_sel), .b_data(b_data),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .pend(pend), .err(err)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit grant_a();
    return qa_s.size() > 0 && (qb_s.size() == 0 || last_b);
  endfunction

  task automatic check_all();
    logic [7:0] p = 8'd0;
    bit ga = grant_a();
    bit any = (qa_s.size() + qb_s.size()) > 0;
    foreach (qa_s[i]) p[qa_s[i]] = 1'b1;
    foreach (qb_s[i]) p[qb_s[i]] = 1'b1;
    chk("a_ready", a_ready, rst && qa_s.size() < D);
    chk("b_ready", b_ready, rst && qb_s.size() < D);
    chk("wr_en", wr_en, any);
    chk("wr_sel", wr_sel, ga ? qa_s[0] : (any ? qb_s[0] : 3'd0));
    chk("wr_data", wr_data, ga ? qa_d[0] : (any ? qb_d[0] : '0));
    chk("pend", pend, p);
    chk("err", err, m_err);
  endtask

  task automatic model_edge();
    bit aacc, bacc, ga, gb;
    if (!rst) return;
    aacc = a_valid && qa_s.size() < D;
    bacc = b_valid && qb_s.size() < D;
    ga = grant_a();
    gb = qb_s.size() > 0 && !ga;
    foreach (qb_s[i]) if (aacc && qb_s[i] == a_sel) m_err = 1;
    foreach (qa_s[i]) if (bacc && qa_s[i] == b_sel) m_err = 1;
    if (aacc && bacc && a_sel == b_sel) m_err = 1;
    if (ga) begin void'(qa_s.pop_front()); void'(qa_d.pop_front()); last_b = 0; end
    if (gb) begin void'(qb_s.pop_front()); void'(qb_d.pop_front()); last_b = 1; end
    if (aacc) begin qa_s.push_back(a_sel); qa_d.push_back(a_data); end
    if (bacc) begin qb_s.push_back(b_sel); qb_d.push_back(b_data); end
  endtask

  task automatic step(bit av, logic [2:0] as, logic [BW-1:0] ad, bit bv, logic [2:0] bs, logic [BW-1:0] bd);
    @(negedge clk);
    check_all();
    a_valid = av; a_sel = as; a_data = ad;
    b_valid = bv; b_sel = bs; b_data = bd;
    @(posedge clk);
    model_edge();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2 rst = 0;
    #1;
    qa_s.delete(); qa_d.delete(); qb_s.delete(); qb_d.delete();
    last_b = 1; m_err = 0;
    check_all();
    idle(2);
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    #12;
    check_all();
    @(negedge clk);
    rst = 1;
    step(1, 3, 16'hBEEF, 0, 0, 0);
    idle(2);
    for (int i = 0; i < 10; i++) step(1, 1, 16'(i + 1), 1, 2, 16'(i + 100));
    idle(3);
    for (int i = 1; i <= 5; i++) step(1, 4, 16'(i), 0, 0, 0);
    idle(3);
    for (int i = 0; i < 6; i++) step(1, 7, 16'(i + 50), 1, 6, 16'(i + 60));
    idle(4);
    step(1, 5, 16'h0055, 0, 0, 0);
    step(0, 0, 0, 1, 5, 16'h0155);
    idle(4);
    @(negedge clk);
    chk("err_sticky", err, 1);
    for (int i = 0; i < 4; i++) step(1, 3'(i), 16'(i), 1, 3'(i + 4), 16'(i + 8));
    mid_reset();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 3'($urandom), 16'($urandom),
           $urandom_range(0, 2) != 0, 3'($urandom), 16'($urandom));
    mid_reset();
    for (int i = 0; i < 200; i++)
      step($urandom_range(0, 1), 3'($urandom_range(0, 3)), 16'($urandom),
           $urandom_range(0, 1), 3'($urandom_range(4, 7)), 16'($urandom));
    idle(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 Parameter BITWIDTH, default 16, SHALL set the data width, matching the 8-entry register file write port.
REQ-002 Parameter DEPTH, default 2, SHALL set the entries per requester queue (power of two, >=2).
REQ-003 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous reset, active-low (asserted at 0).
REQ-006 a_valid/a_ready  in/out  1/1  requester A (ALU writeback) handshake.
REQ-007 a_sel/a_data  in  3/BITWIDTH  requester A destination register and value.
REQ-008 b_valid/b_ready  in/out  1/1  requester B (load writeback) handshake.
REQ-009 b_sel/b_data  in  3/BITWIDTH  requester B destination register and value.
REQ-010 wr_en/wr_sel/wr_data  out  1/3/BITWIDTH  drive the register file write port.
REQ-011 pend  out  8  per-register pending-write bitmap, bit r = register r.
REQ-012 err  out  1  sticky cross-requester write-ordering hazard flag.

Function
REQ-013 Each requester SHALL own a FIFO of DEPTH entries {sel, data}; a transfer occurs at a rising edge with valid=1 and ready=1.
REQ-014 x_ready SHALL be 1 exactly when FIFO x is not full and rst is deasserted; ready SHALL NOT depend on valid or on a same-cycle dequeue (no pass-through when full).
REQ-015 wr_en SHALL be 1 whenever at least one FIFO is non-empty; wr_sel/wr_data SHALL be the granted FIFO head; wr_data/wr_sel SHALL be 0 when wr_en=0.
REQ-016 The granted head SHALL be dequeued at the same edge that commits it to the register file (one write per cycle, never stalled).
REQ-017 Latency: an entry accepted at edge E SHALL appear on wr_* no earlier than the cycle after E; no combinational path from a_*/b_* inputs to wr_*.
REQ-018 Arbitration: one FIFO non-empty -> grant it; both non-empty -> grant the one not granted last (round-robin bit); round-robin bit SHALL update only on a grant.
REQ-019 Per-requester order SHALL be preserved; FIFO read/write pointers SHALL wrap modulo DEPTH, and simultaneous enqueue/dequeue SHALL keep occupancy constant.
REQ-020 pend[r] SHALL be 1 exactly when any valid entry in either FIFO has sel=r (reflects FIFO contents; set the cycle after acceptance, clear the cycle after the committing edge).
REQ-021 err SHALL set at an edge where A is accepted with a_sel matching a valid B entry, B is accepted with b_sel matching a valid A entry, or both are accepted with a_sel=b_sel; err SHALL clear only on reset.
REQ-022 Entries from the same requester to the same register SHALL NOT set err.

Reset
REQ-023 rst=0 SHALL immediately (asynchronously) empty both FIFOs, zero pointers, and force wr_en=0, wr_sel=0, wr_data=0, pend=0, err=0, a_ready=0, b_ready=0.
REQ-024 After reset the round-robin bit SHALL favor A; a_ready=b_ready=1 in the first cycle after rst returns to 1.
REQ-025 Reset asserted mid-operation SHALL discard all queued writes; no wr_en pulse SHALL occur while rst=0.

Verification
REQ-026 Reset: fill both FIFOs, drive rst=0 between edges -> wr_en, pend, err, ready all 0 immediately; after release ready=1, pend=0x00.
REQ-027 Single write: A sel=3 data=0xBEEF accepted at edge E -> cycle after E wr_en=1, wr_sel=3, wr_data=0xBEEF, pend=0x08; following cycle wr_en=0, pend=0x00.
REQ-028 Contention: A and B valid every cycle (A sel=1, B sel=2) -> write order A,B,A,B,...; wr_sel 1,2,1,2; err=1 never asserted.
REQ-029 Backpressure/wrap: B idle, A valid every cycle with data 1..5 sel=4 -> wr_data 1,2,3,4,5 in order, no loss or duplicate, a_ready never 0 once writes drain one per cycle.
REQ-030 Full: B presents 3 entries while A holds grant alternately with DEPTH=2 -> b_ready=0 when B FIFO holds 2 entries, b_ready=1 the cycle after a B dequeue.
REQ-031 Hazard: A accepted sel=5, then B accepted sel=5 while pend[5]=1 -> err=1 next cycle and remains 1 until rst=0.
